// File: rtl/s27_bist_ctrl.sv
// s27_bist_ctrl
//   Built-in self-test sequencer for the s27 sequential core (CUT).
//   A run holds the CUT in synchronous reset, then drives PAT_COUNT
//   pseudo-random patterns from an 8-bit LFSR onto the CUT inputs. The G17
//   response is folded into a 16-bit MISR. The final signature is compared
//   with a golden value, so an altered core is flagged by pass=0.
//
// Parameters
//   PAT_COUNT   patterns per run, 1..65535
//   RST_CYCLES  cycles the CUT reset is held before the patterns, 1..255
//   LFSR_SEED   pattern LFSR seed; an all-zero seed is replaced by 8'h01
//
// Ports
//   CK          in   clock; all state changes on the rising edge
//   reset       in   asynchronous, active-low controller reset
//   start       in   begin a run; honoured only in IDLE or DONE
//   abort       in   cancel a run in progress; wins over start
//   golden_sig  in   expected signature, sampled in COMPARE
//   cut_out     in   CUT G17 response
//   cut_in      out  CUT inputs {G3,G2,G1,G0}
//   cut_reset   out  CUT synchronous reset, active high
//   busy        out  high in RST_CUT, RUN and COMPARE
//   done        out  high in DONE
//   pass        out  signature matched golden_sig; valid while done=1
//   signature   out  current MISR value
module s27_bist_ctrl #(
  parameter int unsigned PAT_COUNT  = 200,
  parameter int unsigned RST_CYCLES = 2,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic        CK,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] golden_sig,
  input  logic        cut_out,
  output logic [3:0]  cut_in,
  output logic        cut_reset,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [7:0]  SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [15:0] PAT_LAST = 16'(PAT_COUNT - 1);
  localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_CUT = 3'd1,
    RUN     = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Maximal-length LFSR, taps 8,6,5,4.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Single-input MISR step, taps 16,14,13,11, response injected at bit 0.
  function automatic logic [15:0] misr_next(input logic [15:0] s, input logic d);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ d};
  endfunction

  state_t      state;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_nxt;
  logic [7:0]  rst_cnt;
  logic [15:0] pat_cnt;
  logic        in_run;

  assign lfsr_nxt = lfsr_next(lfsr);
  assign in_run   = (state == RST_CUT) || (state == RUN) || (state == COMPARE);

  // Sequencer: state, LFSR, MISR, counters and all registered outputs.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lfsr      <= SEED;
      rst_cnt   <= 8'd0;
      pat_cnt   <= 16'd0;
      cut_in    <= 4'd0;
      cut_reset <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= 16'd0;
    end else if (abort && in_run) begin
      // Abort drops everything except the partial signature.
      state     <= IDLE;
      cut_in    <= 4'd0;
      cut_reset <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && !abort) begin
            state     <= RST_CUT;
            lfsr      <= SEED;
            signature <= 16'd0;
            rst_cnt   <= 8'd0;
            pat_cnt   <= 16'd0;
            cut_in    <= 4'd0;
            cut_reset <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end else begin
            state <= state;
          end
        end
        RST_CUT: begin
          if (rst_cnt == RST_LAST) begin
            // The first pattern goes out together with the reset release.
            state     <= RUN;
            cut_reset <= 1'b0;
            cut_in    <= lfsr[3:0];
          end else begin
            rst_cnt <= rst_cnt + 8'd1;
          end
        end
        RUN: begin
          // cut_out belongs to the pattern currently on cut_in.
          lfsr      <= lfsr_nxt;
          signature <= misr_next(signature, cut_out);
          if (pat_cnt == PAT_LAST) begin
            state  <= COMPARE;
            cut_in <= 4'd0;
          end else begin
            pat_cnt <= pat_cnt + 16'd1;
            cut_in  <= lfsr_nxt[3:0];
          end
        end
        COMPARE: begin
          state <= DONE;
          pass  <= (signature == golden_sig);
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cut_in    <= 4'd0;
          cut_reset <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          pass      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// tb_s27_bist_ctrl
//   Bench for s27_bist_ctrl with default parameters. A short vector table
//   covers reset, start/abort priority and the first patterns; full runs
//   with random CUT responses are checked cycle by cycle against a
//   timeline model of what each output must show t cycles after start.
module tb_s27_bist_ctrl;

  localparam int         P    = 200;
  localparam int         R    = 2;
  localparam logic [7:0] SEED = 8'hA5;

  logic        CK = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] golden_sig = 16'd0;
  logic        cut_out = 1'b0;
  logic [3:0]  cut_in;
  logic        cut_reset;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [23:0] obs;

  int total = 0;
  int bad   = 0;
  logic [3:0] pats [P];

  s27_bist_ctrl #(.PAT_COUNT(P), .RST_CYCLES(R), .LFSR_SEED(SEED)) dut (
    .CK(CK), .reset(reset), .start(start), .abort(abort),
    .golden_sig(golden_sig), .cut_out(cut_out), .cut_in(cut_in),
    .cut_reset(cut_reset), .busy(busy), .done(done), .pass(pass),
    .signature(signature)
  );

  always #5 CK = ~CK;

  assign obs = {cut_in, cut_reset, busy, done, pass, signature};

  function automatic logic [23:0] mk(input logic [3:0] ci, input logic cr, input logic b,
                                     input logic d, input logic p, input logic [15:0] s);
    return {ci, cr, b, d, p, s};
  endfunction

  // Signature update as polynomial feedback: parity of tapped bits.
  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic b);
    return {s[14:0], (^(s & 16'hB400)) ^ b};
  endfunction

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp, input int t);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got={ci,cr,busy,done,pass,sig}=%h want=%h", nm, t, act, exp);
    end
  endtask

  // One run started from IDLE/DONE. mode: 0 cut_out=0, 1 only first
  // pattern 1, 2 random. abort_at: cycle after start to abort (-1 none).
  task automatic do_run(input int mode, input int abort_at, input bit match);
    logic [15:0] es;
    logic [23:0] e;
    logic        b;
    int          k;
    es = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= R + P + 2; t++) begin
      if (t <= R)              e = mk(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
      else if (t <= R + P)     e = mk(pats[t-R-1], 1'b0, 1'b1, 1'b0, 1'b0, es);
      else if (t == R + P + 1) e = mk(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, es);
      else                     e = mk(4'd0, 1'b0, 1'b0, 1'b1, match, es);
      check("run", obs, e, t);
      if (t == abort_at) begin
        abort = 1'b1;
        cut_out = 1'b0;
        tick();
        abort = 1'b0;
        check("abort", obs, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, es), t + 1);
        tick();
        check("abort_idle", obs, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, es), t + 2);
        return;
      end
      if (t > R && t <= R + P) begin
        k = t - R - 1;
        if (mode == 0)      b = 1'b0;
        else if (mode == 1) b = (k == 0);
        else                b = 1'($urandom_range(0, 1));
        cut_out = b;
        es = sig_step(es, b);
        if (t == R + P) golden_sig = match ? es : (es ^ 16'h8001);
      end else begin
        cut_out = 1'($urandom_range(0, 1));
      end
      if (t < R + P + 2) tick();
    end
    // DONE must hold pass and signature regardless of golden_sig.
    golden_sig = ~golden_sig;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("done_hold", obs, mk(4'd0, 1'b0, 1'b0, 1'b1, match, es), R + P + 3 + i);
    end
  endtask

  typedef struct {
    logic        st;
    logic        ab;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v;
    v = SEED;
    for (int k = 0; k < P; k++) begin
      pats[k] = v[3:0];
      v = {v[6:0], ^(v & 8'hB8)};
    end

    tbl[0]  = '{1'b0, 1'b0, mk(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0)};
    tbl[1]  = '{1'b1, 1'b1, mk(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0)};
    tbl[2]  = '{1'b0, 1'b1, mk(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0)};
    tbl[3]  = '{1'b1, 1'b0, mk(4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0)};
    tbl[4]  = '{1'b0, 1'b0, mk(4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0)};
    tbl[5]  = '{1'b0, 1'b0, mk(4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0)};
    tbl[6]  = '{1'b1, 1'b0, mk(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0)};
    tbl[7]  = '{1'b0, 1'b0, mk(4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0)};
    tbl[8]  = '{1'b0, 1'b0, mk(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0)};
    tbl[9]  = '{1'b0, 1'b0, mk(4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0)};
    tbl[10] = '{1'b0, 1'b1, mk(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0)};
    tbl[11] = '{1'b0, 1'b1, mk(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0)};

    // Reset held, then released.
    #2 reset = 1'b0;
    #20;
    check("reset_hold", obs, 24'd0, 0);
    @(negedge CK);
    reset = 1'b1;
    tick();
    check("reset_release", obs, 24'd0, 0);

    // Vector table: start/abort priority, CUT reset window, first patterns.
    cut_out = 1'b0;
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st;
      abort = tbl[i].ab;
      tick();
      check($sformatf("vec%0d", i), obs, tbl[i].exp, i);
    end
    start = 1'b0;
    abort = 1'b0;

    do_run(0, -1, 1'b1);          // all-zero response, golden 0
    do_run(1, -1, 1'b0);          // single 1 then mismatch, started from DONE
    do_run(2, R + 50, 1'b1);      // abort at RUN cycle 50
    do_run(2, -1, 1'b1);          // rerun after abort
    do_run(2, 1, 1'b1);           // abort in RST_CUT
    do_run(2, R + P + 1, 1'b1);   // abort in COMPARE
    do_run(2, R + P, 1'b0);       // abort on last pattern
    for (int i = 0; i < 3; i++) do_run(2, -1, 1'($urandom_range(0, 1)));

    // Asynchronous reset in the middle of a run.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    #2 reset = 1'b0;
    #1;
    check("async_reset", obs, 24'd0, 0);
    @(negedge CK);
    reset = 1'b1;
    tick();
    check("async_release", obs, 24'd0, 0);

    do_run(2, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
